// File: rtl/dbg_step_ctrl_if.sv
// Run-control bundle between the board/debug side and dbg_step_ctrl:
// raw buttons and breakpoint inputs in, core control and status out.
interface dbg_step_ctrl_if #(
  parameter int unsigned STEP_W = 16
);
  logic              btn_brk;
  logic              btn_cont;
  logic              btn_step;
  logic [31:0]       pc;
  logic [31:0]       bp_addr;
  logic              bp_valid;
  logic              brk;
  logic              cont;
  logic              halted;
  logic              bp_hit;
  logic [STEP_W-1:0] step_count;

  modport master (
    output btn_brk, btn_cont, btn_step, pc, bp_addr, bp_valid,
    input  brk, cont, halted, bp_hit, step_count
  );

  modport slave (
    input  btn_brk, btn_cont, btn_step, pc, bp_addr, bp_valid,
    output brk, cont, halted, bp_hit, step_count
  );
endinterface

// File: rtl/dbg_step_ctrl.sv
// Button-driven RUN/HALT/STEP run control for the core's brk/cont inputs.
// Define DBG_BRKPT_EN to add the PC breakpoint comparator and sticky bp_hit.
module dbg_step_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int unsigned STEP_W          = 16,
  parameter bit          START_HALTED    = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  dbg_step_ctrl_if.slave dbg
);
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_RST  = START_HALTED ? ST_HALT : ST_RUN;

  logic [2:0]  btn_raw;
  logic [2:0]  sync1_q, sync2_q, acc_q, acc_prev_q, press_q;
  logic [15:0] cnt_q [3];

  // Bit order for all per-button vectors: 0 = brk, 1 = cont, 2 = step.
  assign btn_raw = {dbg.btn_step, dbg.btn_cont, dbg.btn_brk};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      acc_q      <= '0;
      acc_prev_q <= '0;
      press_q    <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      acc_prev_q <= acc_q;
      press_q    <= acc_q & ~acc_prev_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == acc_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
          acc_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  logic [1:0]        state_q, state_d;
  logic              brk_q, brk_d, cont_q, cont_d, halted_q, halted_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              bp_match;
  logic              leave_halt;

  always_comb begin
    state_d    = state_q;
    brk_d      = brk_q;
    cont_d     = 1'b0;
    halted_d   = halted_q;
    step_cnt_d = step_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (press_q[0] || bp_match) begin
          state_d  = ST_HALT;
          brk_d    = 1'b1;
          halted_d = 1'b1;
        end
      end
      ST_HALT: begin
        // Continue wins over step when both presses land together.
        if (press_q[1]) begin
          state_d  = ST_RUN;
          brk_d    = 1'b0;
          cont_d   = 1'b1;
          halted_d = 1'b0;
        end else if (press_q[2]) begin
          state_d    = ST_STEP;
          brk_d      = 1'b0;
          cont_d     = 1'b1;
          halted_d   = 1'b0;
          step_cnt_d = step_cnt_q + STEP_W'(1);
        end
      end
      ST_STEP: begin
        state_d  = ST_HALT;
        brk_d    = 1'b1;
        halted_d = 1'b1;
      end
      default: begin
        state_d  = ST_HALT;
        brk_d    = 1'b1;
        halted_d = 1'b1;
      end
    endcase
  end

  assign leave_halt = (state_q == ST_HALT) && (state_d != ST_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RST;
      brk_q      <= START_HALTED;
      cont_q     <= 1'b0;
      halted_q   <= START_HALTED;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      brk_q      <= brk_d;
      cont_q     <= cont_d;
      halted_q   <= halted_d;
      step_cnt_q <= step_cnt_d;
    end
  end

`ifdef DBG_BRKPT_EN
  logic bp_hit_q, bp_mask_q;

  // Mask stops an immediate re-halt while the PC still sits on the breakpoint.
  assign bp_match = (state_q == ST_RUN) && dbg.bp_valid &&
                    (dbg.pc == dbg.bp_addr) && !bp_mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_hit_q  <= 1'b0;
      bp_mask_q <= 1'b0;
    end else begin
      if ((state_q == ST_RUN) && (state_d == ST_HALT)) bp_hit_q <= bp_match;
      else if (state_d != ST_HALT)                     bp_hit_q <= 1'b0;
      if (leave_halt)                     bp_mask_q <= 1'b1;
      else if (dbg.pc != dbg.bp_addr)     bp_mask_q <= 1'b0;
    end
  end

  assign dbg.bp_hit = bp_hit_q;
`else
  logic unused_bp;
  assign unused_bp  = ^{dbg.pc, dbg.bp_addr, dbg.bp_valid, leave_halt};
  assign bp_match   = 1'b0;
  assign dbg.bp_hit = 1'b0;
`endif

  assign dbg.brk        = brk_q;
  assign dbg.cont       = cont_q;
  assign dbg.halted     = halted_q;
  assign dbg.step_count = step_cnt_q;
endmodule
